// File: rtl/data_sram_ctrl_pkg.sv
// data_sram_ctrl_pkg
//   Shared definitions for the data-side SRAM controller:
//   - sram_state_e : controller FSM states (also exported on the debug port)
//   - SEL_*        : MEM-stage access-size codes carried on mem_sel
//   - be_decode()  : mem_sel -> active-low byte enables for writes
package data_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ACC   = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_WR_DONE  = 3'd6,
        ST_NOP_DONE = 3'd7
    } sram_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_H    = 2'b10;
    localparam logic [1:0] SEL_W    = 2'b11;

    // Sub-word writes land in the low lanes; MEM has already zero-extended
    // the data, so only the enabled lanes matter to the SRAM.
    function automatic logic [3:0] be_decode(input logic [1:0] sel);
        logic [3:0] be_n;
        case (sel)
            SEL_B:   be_n = 4'b1110;
            SEL_H:   be_n = 4'b1100;
            SEL_W:   be_n = 4'b0000;
            default: be_n = 4'b1111;
        endcase
        return be_n;
    endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
//   Turns MEM-stage level-held read/write requests into sequenced strobes
//   for an asynchronous external SRAM and reports completion.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   read_ce, write_ce   : level requests from MEM
//   address, wdata      : word address (low ADDR_W bits used), write data
//   mem_sel             : access size (SEL_NONE/SEL_B/SEL_H/SEL_W)
//   rom_rdata           : latched read word
//   rfin, wfin          : level completion flags
//   sram_*              : SRAM address, active-low strobes/enables, data
//                         out/in and tri-state control (1 = released)
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a request (read_ce or write_ce) is only sampled in IDLE and
// must stay high until its fin flag is seen. The fin flag stays high while
// the request stays high and clears the cycle after the edge on which the
// request is first sampled low; the request must be low for at least one
// edge before a new access can start. All outputs are registered.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_ce,
    input  logic              write_ce,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    input  logic [1:0]        mem_sel,
    output logic [31:0]       rom_rdata,
    output logic              rfin,
    output logic              wfin,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_t,
    output sram_state_e       dbg_state
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    // Counter runs from WAIT_CYCLES-1 down to 0, so the strobe lasts
    // exactly WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             nop_wr;   // NOP access was a write (selects fin/request)

    assign dbg_state = state;

    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[31:ADDR_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            nop_wr    <= 1'b0;
            rom_rdata <= '0;
            rfin      <= 1'b0;
            wfin      <= 1'b0;
            sram_addr <= '0;
            sram_be_n <= 4'b1111;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_dq_o <= '0;
            sram_dq_t <= 1'b1;
        end else begin
            // Outputs describe the state being entered: default everything
            // inactive, each branch re-asserts what its next state needs.
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_dq_t <= 1'b1;
            rfin      <= 1'b0;
            wfin      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (write_ce || read_ce) begin
                        sram_addr <= address[ADDR_W-1:0];
                        sram_dq_o <= wdata;
                        nop_wr    <= write_ce;
                        if (mem_sel == SEL_NONE) begin
                            state     <= ST_NOP_DONE;
                            sram_be_n <= be_decode(SEL_NONE);
                            if (write_ce) begin
                                wfin <= 1'b1;
                            end else begin
                                rfin      <= 1'b1;
                                rom_rdata <= '0;
                            end
                        end else if (write_ce) begin
                            // Write wins when both requests are present.
                            state     <= ST_WR_SETUP;
                            sram_be_n <= be_decode(mem_sel);
                            sram_ce_n <= 1'b0;
                            sram_dq_t <= 1'b0;
                        end else begin
                            state     <= ST_RD_ACC;
                            sram_be_n <= 4'b0000;
                            wait_cnt  <= CNT_LOAD;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                        end
                    end
                end

                ST_RD_ACC: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_RD_DONE;
                        rom_rdata <= sram_dq_i;
                        rfin      <= 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt - CNT_W'(1);
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end
                end

                ST_RD_DONE: begin
                    if (read_ce) rfin  <= 1'b1;
                    else         state <= ST_IDLE;
                end

                ST_WR_SETUP: begin
                    state     <= ST_WR_PULSE;
                    wait_cnt  <= CNT_LOAD;
                    sram_ce_n <= 1'b0;
                    sram_we_n <= 1'b0;
                    sram_dq_t <= 1'b0;
                end

                ST_WR_PULSE: begin
                    sram_ce_n <= 1'b0;
                    sram_dq_t <= 1'b0;
                    if (wait_cnt == '0) begin
                        state <= ST_WR_HOLD;
                    end else begin
                        wait_cnt  <= wait_cnt - CNT_W'(1);
                        sram_we_n <= 1'b0;
                    end
                end

                ST_WR_HOLD: begin
                    state <= ST_WR_DONE;
                    wfin  <= 1'b1;
                end

                ST_WR_DONE: begin
                    if (write_ce) wfin  <= 1'b1;
                    else          state <= ST_IDLE;
                end

                ST_NOP_DONE: begin
                    if (nop_wr ? write_ce : read_ce) begin
                        wfin <= nop_wr;
                        rfin <= !nop_wr;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Data-side external SRAM controller sitting directly downstream of the MEM stage. Converts the MEM stage's level-held read/write requests (`read_ce`/`write_ce` with word address, write data and `mem_sel` size) into correctly sequenced asynchronous SRAM strobes. Returns read data and `rfin`/`wfin` completion flags. The UART address is decoded in MEM, so this block never receives UART accesses.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word-address width
- `WAIT_CYCLES`, 1, SRAM access/strobe length in clk cycles (≥1)

Ports:
- `clk`  in  1  system clock; one clock domain, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `read_ce`  in  1  read request; held high by MEM until `rfin` seen
- `write_ce`  in  1  write request; held high by MEM until `wfin` seen
- `address`  in  32  word address from MEM; `address[ADDR_W-1:0]` used
- `wdata`  in  32  write data, already zero-extended by MEM
- `mem_sel`  in  2  access size: 00 none, 01 byte, 10 half, 11 word
- `rom_rdata`  out  32  latched read data (full word)
- `rfin`  out  1  read complete, level
- `wfin`  out  1  write complete, level
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_be_n`  out  4  byte enables, active-low
- `sram_ce_n` / `sram_oe_n` / `sram_we_n`  out  1 each  SRAM strobes, active-low
- `sram_dq_o`  out  32  data to SRAM
- `sram_dq_i`  in  32  data from SRAM
- `sram_dq_t`  out  1  1 = tri-state (top ties the three to the inout pad)

## Operation
- States: IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE, NOP_DONE.
- IDLE: strobes high, `sram_dq_t`=1, fin flags 0. Sampling an edge:
  - `write_ce`=1: go to WR_SETUP. Write wins if both requests are high.
  - Else `read_ce`=1: go to RD_ACC.
  - If `mem_sel`=00 with either request: go to NOP_DONE. No strobe.
- Address, `wdata` and `be_n` are registered on leaving IDLE and held constant for the whole access.
- RD_ACC:
  - `ce_n`=0, `oe_n`=0, `be_n`=0000.
  - Lasts WAIT_CYCLES cycles.
  - On the last edge, latch `sram_dq_i` into `rom_rdata` and go to RD_DONE.
- RD_DONE: `rfin`=1, strobes high. Stay while `read_ce`=1; go to IDLE on the first edge with `read_ce`=0.
- WR_SETUP: 1 cycle. `ce_n`=0, `we_n`=1, `dq_t`=0, data driven.
- WR_PULSE: `we_n`=0 for WAIT_CYCLES cycles.
- WR_HOLD: 1 cycle. `we_n`=1, `ce_n`=0, data still driven.
- WR_DONE: `wfin`=1, `dq_t`=1. Stay while `write_ce`=1; go to IDLE when it drops.
- NOP_DONE: the `rfin` or `wfin` matching the request is 1. For a read, `rom_rdata` is forced to 0. Exit to IDLE when the request drops.
- Byte enables for writes:
  - `mem_sel` 01 → 1110
  - `mem_sel` 10 → 1100
  - `mem_sel` 11 → 0000
- Requests are ignored in every state except IDLE. A new access requires the request to be low for at least one edge after completion.
- `oe_n` and `we_n` are never both low. `dq_t` is 0 only in WR_SETUP, WR_PULSE and WR_HOLD.

## Timing
- Reset (`rst`=0, async, effective immediately):
  - State IDLE.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n`=1, `sram_be_n`=1111, `sram_dq_t`=1.
  - `sram_addr`=0, `sram_dq_o`=0, `rom_rdata`=0, `rfin`=`wfin`=0.
- Reset asserted mid-access aborts the access; no completion flag is produced.
- Let E0 be the edge at which a request is sampled.
- Read: `rfin` goes high after edge E0+WAIT_CYCLES (default 1). `rom_rdata` is valid in the same cycle.
- Write: `wfin` goes high after edge E0+WAIT_CYCLES+2 (default 3).
- Fin flags clear the cycle after the edge at which the request is seen low.
- All outputs are registered (Moore).
- `rom_rdata` holds its value until the next read's latch edge, or until a NOP read.

## Structure
- Shared package holds:
  - the state enum;
  - the `mem_sel` constants `SEL_NONE`/`SEL_B`/`SEL_H`/`SEL_W`;
  - a byte-enable decode function.
- One wait counter of width `$clog2(WAIT_CYCLES+1)`, reloaded on entry to RD_ACC and WR_PULSE.
- No sub-module; a single FSM plus datapath registers.

## Test plan
- Reset, then idle 5 cycles → all strobes 1, `be_n`=1111, `dq_t`=1, flags 0.
- `read_ce`=1, address 0x00000123, `sram_dq_i`=0xDEADBEEF → `sram_addr`=0x00123, `oe_n`/`ce_n` low 1 cycle, `rfin`=1 with `rom_rdata`=0xDEADBEEF. `rfin` stays high until `read_ce` drops, then IDLE.
- `write_ce`=1, `mem_sel`=01, address 0x40, `wdata`=0x000000A5:
  - `be_n`=1110;
  - `we_n` low exactly 1 cycle, framed by 1 setup cycle and 1 hold cycle with `dq_o`=0x000000A5;
  - `wfin` at E0+3.
- Both `read_ce` and `write_ce` high → write sequence only, `oe_n` never low, only `wfin` asserts.
- `mem_sel`=00 read → no strobe activity, `rfin`=1 at E0+1, `rom_rdata`=0.
- `rst` pulled low during WR_PULSE → `we_n`/`ce_n` high and `dq_t`=1 immediately. `wfin` never asserts. After release the controller is in IDLE; WAIT_CYCLES=3 rerun gives `we_n` low for 3 cycles.
